uart_tx_sched: RTL and testbench

Round-robin scheduler that shares a single UART transmitter among `N_REQ` byte producers. Each producer presents a byte plus its own frame configuration (stop bits, parity) over a valid/ready handshake. The scheduler accepts one byte at a time, drives the transmitter's data/config inputs and a one-cycle start pulse, then tracks the transmitter's busy flag until the frame completes. It sits between the system-side producers and the UART Tx datapath, with a watchdog on the start handshake and a wrapping frame counter for status.

---
 rtl/uart_tx_sched_if.sv | 44 ++++
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_if
//   Bundles the producer-side byte handshake and the transmitter-side launch
//   signals that pass through the UART Tx scheduler.
//
//   Producer side (one lane per requester):
//     req_valid[k]       byte k is offered
//     req_data[8k+7:8k]  byte for requester k
//     req_two_stop[k]    requester k wants two stop bits
//     req_odd_parity[k]  requester k wants odd parity
//     req_ready          one-hot accept strobe back to the producers
//   Transmitter side:
//     tx_data, tx_two_stop, tx_odd_parity   registered frame contents
//     tx_start                              one-cycle launch pulse
//     tx_busy                               frame-in-progress flag
//
//   master: the scheduler.  slave: producers plus the transmitter.
//   N_REQ must match the N_REQ of the scheduler it is connected to.
// -----------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*8-1:0] req_data;
    logic [N_REQ-1:0]   req_two_stop;
    logic [N_REQ-1:0]   req_odd_parity;
    logic [N_REQ-1:0]   req_ready;

    logic [7:0]         tx_data;
    logic               tx_two_stop;
    logic               tx_odd_parity;
    logic               tx_start;
    logic               tx_busy;

    modport master (
        input  req_valid, req_data, req_two_stop, req_odd_parity, tx_busy,
        output req_ready, tx_data, tx_two_stop, tx_odd_parity, tx_start
    );

    modport slave (
        output req_valid, req_data, req_two_stop, req_odd_parity, tx_busy,
        input  req_ready, tx_data, tx_two_stop, tx_odd_parity, tx_start
    );
endinterface

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Round-robin scheduler sharing one UART transmitter among N_REQ byte
//   producers. One byte is accepted per IDLE cycle, latched into the tx_*
//   registers, launched with a one-cycle tx_start, and then tracked through
//   the transmitter's busy flag. A watchdog catches a transmitter that never
//   acknowledges the start pulse.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-high reset
//     bus          uart_tx_sched_if.master (producer handshake + tx launch)
//     err_clr      clears timeout_err (a new timeout in the same cycle wins)
//     grant_id     index of the last granted requester (resets to N_REQ-1)
//     active       high whenever the FSM is not in IDLE
//     timeout_err  sticky watchdog flag
//     frame_count  frames launched, wraps at 16 bits
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_sched_if.master            bus,
    input  logic                       err_clr,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       timeout_err,
    output logic [15:0]                frame_count
);

    localparam int GW   = $clog2(N_REQ);
    localparam int WD_W = $clog2(START_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(START_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]      state;
    logic [WD_W-1:0] wd_cnt;

    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            found;
    logic            grant_fire;
    logic            timeout_set;
    logic [7:0]      pick_data;

    // Round-robin search starting just after the last grant. The modulo keeps
    // the candidate inside 0..N_REQ-1 even when N_REQ is not a power of two.
    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        pick  = grant_id;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = GW'((int'(grant_id) + i) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A grant needs the transmitter idle as well: tx_busy can still be high
    // from activity this block did not launch.
    assign grant_fire  = (state == S_IDLE) && found && !bus.tx_busy;
    assign timeout_set = (state == S_WAIT_BUSY) && !bus.tx_busy && (wd_cnt == WD_LAST);
    assign pick_data   = bus.req_data[{pick, 3'b000} +: 8];

    always_comb begin
        bus.req_ready = '0;
        if (grant_fire) begin
            bus.req_ready[pick] = 1'b1;
        end
    end

    // Decoded from state so that an asynchronous reset drops them at once.
    assign bus.tx_start = (state == S_LAUNCH);
    assign active       = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            wd_cnt            <= '0;
            grant_id          <= GW'(N_REQ - 1);
            bus.tx_data       <= 8'h00;
            bus.tx_two_stop   <= 1'b0;
            bus.tx_odd_parity <= 1'b0;
            timeout_err       <= 1'b0;
            frame_count       <= 16'h0000;
        end else begin
            // Setting wins over clearing so a timeout is never lost.
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (grant_fire) begin
                        bus.tx_data       <= pick_data;
                        bus.tx_two_stop   <= bus.req_two_stop[pick];
                        bus.tx_odd_parity <= bus.req_odd_parity[pick];
                        grant_id          <= pick;
                        state             <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    frame_count <= frame_count + 16'd1;
                    wd_cnt      <= '0;
                    state       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        // Byte is dropped; the producer already saw its ready.
                        state <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    // Frame length belongs to the transmitter; no timeout here.
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched with N_REQ=4, START_TIMEOUT=64.
//   Inputs change on the falling edge; outputs are sampled there or 1 ns later.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int N_REQ         = 4;
    localparam int START_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_clr;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    uart_tx_sched_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_sched #(
        .N_REQ        (N_REQ),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_clr    (err_clr),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // One complete frame, entered at a falling edge in IDLE with the request
    // inputs already set. Returns what was seen at the grant and launch
    // cycles; leaves at the falling edge of the next IDLE cycle.
    task automatic do_frame(output logic [3:0] rdy, output logic st, output logic [7:0] dat);
        #1 rdy = bus.req_ready;
        @(negedge clk);
        st  = bus.tx_start;
        dat = bus.tx_data;
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst                = 1'b1;
        err_clr            = 1'b0;
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.req_two_stop   = '0;
        bus.req_odd_parity = '0;
        bus.tx_busy        = 1'b0;
        #3;
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_grant_id: got %0d expected 3", grant_id);
        end
        checks++;
        if ({bus.req_ready, bus.tx_start, bus.tx_data, bus.tx_two_stop, bus.tx_odd_parity} !== 15'h0) begin
            errors++;
            $display("FAIL reset_bus_outputs: got %h expected 0",
                     {bus.req_ready, bus.tx_start, bus.tx_data, bus.tx_two_stop, bus.tx_odd_parity});
        end
        checks++;
        if ({active, timeout_err, frame_count} !== 18'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected 0", {active, timeout_err, frame_count});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bus.req_data       = {8'h44, 8'h33, 8'h22, 8'hA5};
        bus.req_two_stop   = 4'b0001;
        bus.req_odd_parity = 4'b0001;
        bus.req_valid      = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if ({bus.tx_start, bus.tx_data, bus.tx_two_stop, bus.tx_odd_parity, bus.req_ready} !== {1'b1, 8'hA5, 1'b1, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL single_launch: got start=%b data=%h two=%b odd=%b ready=%b expected 1 a5 1 1 0000",
                     bus.tx_start, bus.tx_data, bus.tx_two_stop, bus.tx_odd_parity, bus.req_ready);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL single_count_at_launch: got %0d expected 0", frame_count);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b0 || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL single_after_launch: got start=%b count=%0d expected 0 1", bus.tx_start, frame_count);
        end
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (active !== 1'b1 || bus.tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: got active=%b data=%h expected 1 a5", active, bus.tx_data);
        end
        bus.tx_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got active=%b expected 0", active);
        end
    endtask

    task automatic test_reset_mid_frame;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        bus.tx_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL midrst_precond: got active=%b expected 1", active);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({active, bus.tx_start, frame_count, bus.tx_data, grant_id} !== {1'b0, 1'b0, 16'h0, 8'h00, 2'd3}) begin
            errors++;
            $display("FAIL midrst_outputs: got active=%b start=%b count=%0d data=%h grant=%0d expected 0 0 0 00 3",
                     active, bus.tx_start, frame_count, bus.tx_data, grant_id);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.tx_busy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [3:0] rdy;
        logic       st;
        logic [7:0] dat;
        logic [3:0] exp_rdy;
        logic [7:0] exp_dat;
        bus.req_data       = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_two_stop   = 4'b1010;
        bus.req_odd_parity = 4'b0110;
        bus.req_valid      = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            exp_rdy = 4'b0001 << (f % 4);
            exp_dat = 8'h11 * 8'((f % 4) + 1);
            do_frame(rdy, st, dat);
            checks++;
            if (rdy !== exp_rdy || st !== 1'b1 || dat !== exp_dat) begin
                errors++;
                $display("FAIL rr_frame%0d: got ready=%b start=%b data=%h expected %b 1 %h",
                         f, rdy, st, dat, exp_rdy, exp_dat);
            end
        end
        bus.req_valid = '0;
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL rr_last_grant: got %0d expected 3", grant_id);
        end
    endtask

    task automatic test_skip;
        logic [3:0] rdy;
        logic       st;
        logic [7:0] dat;
        bus.req_valid = 4'b0010;
        do_frame(rdy, st, dat);
        checks++;
        if (rdy !== 4'b0010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL skip_setup: got ready=%b grant=%0d expected 0010 1", rdy, grant_id);
        end
        bus.req_valid = 4'b1001;
        do_frame(rdy, st, dat);
        checks++;
        if (rdy !== 4'b1000 || dat !== 8'h44) begin
            errors++;
            $display("FAIL skip_grant3: got ready=%b data=%h expected 1000 44", rdy, dat);
        end
        checks++;
        if (bus.tx_two_stop !== 1'b1 || bus.tx_odd_parity !== 1'b0) begin
            errors++;
            $display("FAIL skip_cfg3: got two=%b odd=%b expected 1 0", bus.tx_two_stop, bus.tx_odd_parity);
        end
        do_frame(rdy, st, dat);
        checks++;
        if (rdy !== 4'b0001 || dat !== 8'h11) begin
            errors++;
            $display("FAIL skip_grant0: got ready=%b data=%h expected 0001 11", rdy, dat);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_watchdog;
        int n;
        bus.req_valid = 4'b0001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wd_ready: got %b expected 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        // Launch cycle is step 0; expiry is visible 65 falling edges later.
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 65 || active !== 1'b0) begin
            errors++;
            $display("FAIL wd_expiry: got cycles=%0d active=%b expected 65 0", n, active);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_clear: got %b expected 0", timeout_err);
        end
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (64) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL wd_pre_expiry: got err=%b active=%b expected 0 1", timeout_err, active);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || active !== 1'b0) begin
            errors++;
            $display("FAIL wd_set_beats_clr: got err=%b active=%b expected 1 0", timeout_err, active);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_busy_hold;
        logic [3:0] rdy;
        logic       st;
        logic [7:0] dat;
        logic       seen_ready;
        seen_ready    = 1'b0;
        bus.tx_busy   = 1'b1;
        bus.req_valid = 4'b0001;
        repeat (5) begin
            @(negedge clk);
            #1 if (bus.req_ready !== 4'b0000 || active !== 1'b0) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready !== 1'b0 || frame_count !== 16'd13) begin
            errors++;
            $display("FAIL busy_hold_no_grant: got granted=%b count=%0d expected 0 13", seen_ready, frame_count);
        end
        @(negedge clk);
        bus.tx_busy = 1'b0;
        do_frame(rdy, st, dat);
        bus.req_valid = '0;
        checks++;
        if (rdy !== 4'b0001 || st !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold_release: got ready=%b start=%b expected 0001 1", rdy, st);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] rdy;
        logic       st;
        logic [7:0] dat;
        checks++;
        if (frame_count !== 16'd14) begin
            errors++;
            $display("FAIL wrap_precount: got %0d expected 14", frame_count);
        end
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        checks++;
        if (frame_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected ffff", frame_count);
        end
        bus.req_valid = 4'b0100;
        do_frame(rdy, st, dat);
        bus.req_valid = '0;
        checks++;
        if (frame_count !== 16'h0000 || rdy !== 4'b0100) begin
            errors++;
            $display("FAIL wrap_count: got count=%h ready=%b expected 0000 0100", frame_count, rdy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_frame();
        test_round_robin();
        test_skip();
        test_watchdog();
        test_busy_hold();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
